led_indicator_bank: RTL and testbench
=====================================

# led_indicator_bank

Parametrised successor to the five-LED character indicator. Consumes the same byte stream (`data` + `ready` strobe, typically from the UART receiver) and drives a bank of `NUM_LEDS` LEDs, each independently off, on, or blinking. Adds a two-byte blink command, all-on/all-clear commands and an error strobe for malformed commands. Sits between the byte receiver and the board LED pins.

## Interface
- `NUM_LEDS`, default 5: number of LEDs; legal range 1..9.
- `BLINK_DIV`, default 6000000: clock cycles per blink half-period; must be at least 2.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: synchronous, active-high; overrides every other input in the same cycle.
- `data` input, 8 bits: ASCII command byte; valid only when `ready`=1.
- `ready` input, 1 bit: byte strobe. Every cycle sampled high counts as one byte.
- `leds` output, `NUM_LEDS` bits: LED drive, active-high. LED k (1-based) maps to `leds[NUM_LEDS-k]`, so LED1 is the MSB.
- `cmd_err` output, 1 bit: one-cycle pulse when a command byte is rejected.

## Operation
- Per-LED mode register, 2 bits each: OFF, ON, BLINK.
- `leds[i]` = (mode==ON) | (mode==BLINK & `phase`). Combinational from registers only.
- Blink timebase is one shared counter, width $clog2(`BLINK_DIV`), counting 0..`BLINK_DIV`-1.
  - At terminal count the counter wraps to 0 and `phase` toggles.
  - The counter is never restarted by commands.
- The command FSM has two states, IDLE and ARG.
- In IDLE, a byte with `ready`=1 is decoded as follows:
  - '1'..('0'+`NUM_LEDS`): toggle LED k. OFF→ON, ON→OFF, BLINK→OFF.
  - 'B' (0x42): go to ARG. No mode change.
  - 'A' (0x41): all LEDs ON.
  - 'C' (0x43): all LEDs OFF.
  - Any other byte, including digits above `NUM_LEDS` and '0': ignored, no `cmd_err`.
- In ARG, a byte with `ready`=1 is decoded as follows:
  - Valid digit k: LED k goes to BLINK, return to IDLE.
  - Any other byte: pulse `cmd_err`, return to IDLE. No mode change; the byte is not re-decoded, so 'B' 'B' leaves the FSM in IDLE.
- Without `ready`, the FSM holds its state indefinitely. There is no timeout.

## Timing
- Reset values:
  - `leds`=0, `cmd_err`=0.
  - All modes OFF, `phase`=0, counter=0, FSM in IDLE.
- Command latency: a byte sampled at edge N changes mode registers at edge N. `leds` reflects it during cycle N+1 (1 cycle).
- `cmd_err` is registered: high for exactly the cycle following the rejecting edge.
- Blink period: `phase`=0 for the first `BLINK_DIV` cycles after reset, then toggles every `BLINK_DIV` cycles. Full period is 2×`BLINK_DIV`.
- A BLINK LED set while `phase`=1 lights immediately; while `phase`=0 it stays dark until the next toggle.
- Back-to-back `ready` on consecutive cycles: each byte is processed in order, one per cycle, no drops.
- Reset during ARG: returns to IDLE; a following digit is a toggle, not a blink.
- Reset asserted together with `ready`: the byte is discarded.

## Test plan
All scenarios use `NUM_LEDS`=5, `BLINK_DIV`=4, with one-cycle `ready` strobes separated by 5 idle cycles.
- Toggle and reset: send '1', '2', '2', then reset, then '1'.
  - `leds` = 10000, then 11000, then 10000.
  - During the reset cycle's following cycle, `leds` = 00000.
  - After the final '1', `leds` = 10000.
- Blink: send 'B', '3'.
  - `leds[2]` follows `phase`: low for cycles 0-3 after reset, high for 4-7, period 8.
  - A following '3' gives `leds` = 00000 steady.
- All/clear and out-of-range: send 'A' → `leds` = 11111. Send '7' → unchanged, `cmd_err` stays 0. Send 'C' → 00000.
- Malformed blink: send 'B', 'x' → one `cmd_err` pulse, `leds` unchanged. A following '2' toggles LED2 to give 01000.
- Reset mid-command: send 'B', reset, '4' → `leds` = 00010 steady, not blinking.
- Back-to-back: `ready` held high for 3 cycles carrying '1', '2', '1' → final `leds` = 01000, with the intermediate value 11000 visible for one cycle.

Source files
------------

// File: rtl/led_indicator_bank_if.sv
// Byte-stream and LED-drive signals between the byte receiver, the indicator bank and the board pins.
// The master side supplies command bytes; the slave side drives the LEDs and the error strobe.
interface led_indicator_bank_if #(
    parameter int NUM_LEDS = 5
);
    logic [7:0]          data;
    logic                ready;
    logic [NUM_LEDS-1:0] leds;
    logic                cmd_err;

    modport master (output data, ready, input leds, cmd_err);
    modport slave  (input data, ready, output leds, cmd_err);
endinterface

// File: rtl/led_indicator_bank.sv
// Bank of NUM_LEDS indicators, each off, on or blinking, commanded by ASCII bytes.
// Supports a two-byte blink command ('B' + digit), all-on ('A') and all-clear ('C').
module led_indicator_bank #(
    parameter int NUM_LEDS  = 5,
    parameter int BLINK_DIV = 6000000
) (
    input  logic                 clk,
    input  logic                 reset,
    led_indicator_bank_if.slave  bus
);
    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(BLINK_DIV - 1);
    localparam logic [7:0] MAX_DIGIT = 8'(48 + NUM_LEDS);

    typedef enum logic [1:0] {MODE_OFF = 2'd0, MODE_ON = 2'd1, MODE_BLINK = 2'd2} mode_t;
    typedef enum logic {IDLE = 1'b0, ARG = 1'b1} state_t;

    state_t              state, state_nxt;
    mode_t               mode     [NUM_LEDS];
    mode_t               mode_nxt [NUM_LEDS];
    logic [CW-1:0]       cnt;
    logic                phase;
    logic                cmd_err_q, err_nxt;
    logic                digit_ok;
    logic [7:0]          led_num;
    logic [NUM_LEDS-1:0] leds_w;

    // Mode register index i drives leds[i]; LED k lives at i = NUM_LEDS-k.
    always_comb begin
        led_num   = bus.data - 8'h30;
        digit_ok  = (bus.data >= 8'h31) && (bus.data <= MAX_DIGIT);
        state_nxt = state;
        err_nxt   = 1'b0;
        for (int i = 0; i < NUM_LEDS; i++) mode_nxt[i] = mode[i];

        if (bus.ready) begin
            case (state)
                IDLE: begin
                    if (digit_ok) begin
                        for (int i = 0; i < NUM_LEDS; i++)
                            if (8'(NUM_LEDS - i) == led_num)
                                mode_nxt[i] = (mode[i] == MODE_OFF) ? MODE_ON : MODE_OFF;
                    end else if (bus.data == 8'h42) begin
                        state_nxt = ARG;
                    end else if (bus.data == 8'h41) begin
                        for (int i = 0; i < NUM_LEDS; i++) mode_nxt[i] = MODE_ON;
                    end else if (bus.data == 8'h43) begin
                        for (int i = 0; i < NUM_LEDS; i++) mode_nxt[i] = MODE_OFF;
                    end
                end
                ARG: begin
                    // The argument byte is consumed either way; a bad one is never re-decoded.
                    state_nxt = IDLE;
                    if (digit_ok) begin
                        for (int i = 0; i < NUM_LEDS; i++)
                            if (8'(NUM_LEDS - i) == led_num) mode_nxt[i] = MODE_BLINK;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The blink timebase free-runs; commands never restart it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            phase     <= 1'b0;
            cmd_err_q <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) mode[i] <= MODE_OFF;
        end else begin
            state     <= state_nxt;
            cmd_err_q <= err_nxt;
            for (int i = 0; i < NUM_LEDS; i++) mode[i] <= mode_nxt[i];
            if (cnt == TERM) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_comb begin
        leds_w = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            leds_w[i] = (mode[i] == MODE_ON) || ((mode[i] == MODE_BLINK) && phase);
    end

    assign bus.leds    = leds_w;
    assign bus.cmd_err = cmd_err_q;
endmodule

// File: tb/tb_led_indicator_bank.sv
// Scoreboard bench for led_indicator_bank: a behavioural model queues the expected
// LED/error state for every cycle, and each cycle's DUT output is compared against it.
module tb_led_indicator_bank;
    localparam int N   = 5;
    localparam int DIV = 4;

    typedef struct {
        logic [N-1:0] leds;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   passCount  = 0;
    exp_t sbq[$];

    int   mmode [1:N];
    bit   marg;
    bit   merr;
    int   cyc;

    always #5 clk = ~clk;

    led_indicator_bank_if #(.NUM_LEDS(N)) bus ();

    led_indicator_bank #(.NUM_LEDS(N), .BLINK_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp)
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            passCount++;
    endtask

    function automatic logic [N-1:0] modelLeds();
        logic [N-1:0] v;
        bit ph;
        v  = '0;
        ph = ((cyc / DIV) % 2) == 1;
        for (int k = 1; k <= N; k++)
            v[N-k] = (mmode[k] == 1) || ((mmode[k] == 2) && ph);
        return v;
    endfunction

    // Modes: 0 off, 1 on, 2 blink. cyc counts edges since the last reset edge.
    function automatic void modelStep(input logic rst, input logic rdy, input logic [7:0] d);
        bit dig;
        int k;
        dig = (d >= 8'h31) && (d <= 8'(48 + N));
        k   = int'(d) - 48;
        if (rst) begin
            for (int j = 1; j <= N; j++) mmode[j] = 0;
            marg = 0; merr = 0; cyc = 0;
            return;
        end
        cyc++;
        merr = 0;
        if (!rdy) return;
        if (marg) begin
            marg = 0;
            if (dig) mmode[k] = 2;
            else     merr = 1;
        end else if (dig) begin
            mmode[k] = (mmode[k] == 0) ? 1 : 0;
        end else if (d == "B") begin
            marg = 1;
        end else if (d == "A") begin
            for (int j = 1; j <= N; j++) mmode[j] = 1;
        end else if (d == "C") begin
            for (int j = 1; j <= N; j++) mmode[j] = 0;
        end
    endfunction

    task automatic applyStimulus(input logic rst, input logic rdy, input logic [7:0] d);
        exp_t e;
        @(negedge clk);
        reset     = rst;
        bus.ready = rdy;
        bus.data  = d;
        modelStep(rst, rdy, d);
        sbq.push_back('{leds: modelLeds(), err: merr});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        checkOutput("leds", 32'(bus.leds), 32'(e.leds));
        checkOutput("cmd_err", 32'(bus.cmd_err), 32'(e.err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic sendByte(input logic [7:0] d);
        applyStimulus(1'b0, 1'b1, d);
        idle(5);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("reset_leds", 32'(bus.leds), 32'h0);
        checkOutput("reset_err", 32'(bus.cmd_err), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        bus.ready = 1'b0;
        bus.data  = 8'h00;
        doReset();

        // Toggle and reset
        sendByte("1");
        checkOutput("toggle1", 32'(bus.leds), 32'b10000);
        sendByte("2");
        checkOutput("toggle2", 32'(bus.leds), 32'b11000);
        sendByte("2");
        checkOutput("toggle2_off", 32'(bus.leds), 32'b10000);
        doReset();
        sendByte("1");
        checkOutput("after_reset_1", 32'(bus.leds), 32'b10000);

        // Blink timing relative to reset
        doReset();
        applyStimulus(1'b0, 1'b1, "B");
        applyStimulus(1'b0, 1'b1, "3");
        checkOutput("blink_c2", 32'(bus.leds[2]), 32'h0);
        idle(1);
        checkOutput("blink_c3", 32'(bus.leds[2]), 32'h0);
        idle(1);
        checkOutput("blink_c4", 32'(bus.leds[2]), 32'h1);
        idle(3);
        checkOutput("blink_c7", 32'(bus.leds[2]), 32'h1);
        idle(1);
        checkOutput("blink_c8", 32'(bus.leds[2]), 32'h0);
        idle(10);
        sendByte("3");
        idle(8);
        checkOutput("blink_cleared", 32'(bus.leds), 32'b00000);

        // All/clear and out-of-range digit
        sendByte("A");
        checkOutput("all_on", 32'(bus.leds), 32'b11111);
        applyStimulus(1'b0, 1'b1, "7");
        checkOutput("digit7_err", 32'(bus.cmd_err), 32'h0);
        idle(5);
        checkOutput("digit7_leds", 32'(bus.leds), 32'b11111);
        sendByte("0");
        sendByte("C");
        checkOutput("clear", 32'(bus.leds), 32'b00000);

        // Malformed blink, then 'B' 'B' leaves the FSM idle
        applyStimulus(1'b0, 1'b1, "B");
        applyStimulus(1'b0, 1'b1, "x");
        checkOutput("bad_arg_err", 32'(bus.cmd_err), 32'h1);
        idle(1);
        checkOutput("bad_arg_pulse_end", 32'(bus.cmd_err), 32'h0);
        idle(4);
        sendByte("2");
        checkOutput("after_bad_arg", 32'(bus.leds), 32'b01000);
        sendByte("B");
        sendByte("B");
        sendByte("2");
        checkOutput("bb_then_toggle", 32'(bus.leds), 32'b00000);

        // Reset mid-command: following digit is a toggle
        sendByte("B");
        doReset();
        sendByte("4");
        idle(8);
        checkOutput("reset_in_arg", 32'(bus.leds), 32'b00010);

        // Reset together with ready discards the byte
        applyStimulus(1'b1, 1'b1, "1");
        checkOutput("reset_with_ready", 32'(bus.leds), 32'b00000);
        idle(3);

        // Back-to-back bytes
        applyStimulus(1'b0, 1'b1, "1");
        applyStimulus(1'b0, 1'b1, "2");
        checkOutput("b2b_mid", 32'(bus.leds), 32'b11000);
        applyStimulus(1'b0, 1'b1, "1");
        checkOutput("b2b_final", 32'(bus.leds), 32'b01000);
        idle(5);

        // Blink set while phase is high lights at once, plus random traffic
        sendByte("B");
        sendByte("5");
        for (int i = 0; i < 200; i++) begin
            logic [7:0] d;
            int r;
            r = $urandom_range(0, 9);
            case (r)
                0: d = "A";
                1: d = "B";
                2: d = "C";
                3: d = "x";
                default: d = 8'(8'h30 + $urandom_range(0, 7));
            endcase
            applyStimulus(1'b0, ($urandom_range(0, 2) != 0), d);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
